// File: rtl/condition_monitor.sv
// Two-stage checker for the `condition` block: S1 registers a qualified sample, S2 compares
// the normal coding styles, detects latch holds against the previous checked sample, and counts events.
module condition_monitor #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sel,
  input  logic [DATA_W-1:0] normal_if,
  input  logic [DATA_W-1:0] normal_case,
  input  logic [DATA_W-1:0] normal_ternary,
  input  logic [DATA_W-1:0] latch_if,
  input  logic [DATA_W-1:0] latch_case,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_sel,
  output logic              result_mismatch,
  output logic              result_hold,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  hold_cnt,
  output logic [1:0]        state,
  output logic              err_sticky
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  // S1 sample registers
  logic              s1_valid;
  logic [DATA_W-1:0] s1_sel;
  logic [DATA_W-1:0] s1_nif;
  logic [DATA_W-1:0] s1_ncase;
  logic [DATA_W-1:0] s1_ntern;
  logic [DATA_W-1:0] s1_lif;
  logic [DATA_W-1:0] s1_lcase;

  // Previous checked sample, used by the hold check
  logic              prev_valid;
  logic [DATA_W-1:0] prev_sel;
  logic [DATA_W-1:0] prev_lif;
  logic [DATA_W-1:0] prev_lcase;

  logic       chk_mismatch;
  logic       chk_hold;
  logic [1:0] state_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    chk_mismatch = (s1_nif != s1_ncase) || (s1_nif != s1_ntern);
    chk_hold     = prev_valid && (s1_sel != prev_sel) &&
                   ((s1_lif == prev_lif) || (s1_lcase == prev_lcase));
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: state_d = chk_mismatch ? ST_FAULT : ST_RUN;
      ST_RUN:  if (chk_mismatch) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default: state_d = ST_IDLE;
    endcase
  end

  // S1 valid bit; clear drops any sample presented alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sample_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sel   <= '0;
      s1_nif   <= '0;
      s1_ncase <= '0;
      s1_ntern <= '0;
      s1_lif   <= '0;
      s1_lcase <= '0;
    end else if (sample_valid && !clear) begin
      s1_sel   <= sel;
      s1_nif   <= normal_if;
      s1_ncase <= normal_case;
      s1_ntern <= normal_ternary;
      s1_lif   <= latch_if;
      s1_lcase <= latch_case;
    end
  end

  // S2: results, counters, previous-sample registers and state all move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid    <= 1'b0;
      result_sel      <= '0;
      result_mismatch <= 1'b0;
      result_hold     <= 1'b0;
    end else if (clear) begin
      result_valid    <= 1'b0;
      result_sel      <= '0;
      result_mismatch <= 1'b0;
      result_hold     <= 1'b0;
    end else begin
      result_valid <= s1_valid;
      if (s1_valid) begin
        result_sel      <= s1_sel;
        result_mismatch <= chk_mismatch;
        result_hold     <= chk_hold;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      hold_cnt     <= '0;
    end else if (clear) begin
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      hold_cnt     <= '0;
    end else if (s1_valid) begin
      sample_cnt <= sat_inc(sample_cnt);
      if (chk_mismatch) mismatch_cnt <= sat_inc(mismatch_cnt);
      if (chk_hold)     hold_cnt     <= sat_inc(hold_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_sel   <= '0;
      prev_lif   <= '0;
      prev_lcase <= '0;
    end else if (clear) begin
      prev_valid <= 1'b0;
      prev_sel   <= '0;
      prev_lif   <= '0;
      prev_lcase <= '0;
    end else if (s1_valid) begin
      prev_valid <= 1'b1;
      prev_sel   <= s1_sel;
      prev_lif   <= s1_lif;
      prev_lcase <= s1_lcase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= ST_IDLE;
    end else if (s1_valid) begin
      state <= state_d;
    end
  end

  assign err_sticky = (state == ST_FAULT);

endmodule
